// File: rtl/wb_mem_tester.sv
// Pipelined Wishbone B4 initiator that fills a word range with seed+i or reads it back and
// counts mismatches against the same pattern.
module wb_mem_tester #(
  parameter int unsigned WB_DATA_WIDTH   = 32,
  parameter int unsigned WB_ADDR_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       cmd_start_i,
  input  logic                       cmd_check_i,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_base_i,
  input  logic [LEN_WIDTH-1:0]       cmd_count_i,
  input  logic [WB_DATA_WIDTH-1:0]   cmd_seed_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [LEN_WIDTH-1:0]       mismatch_cnt_o,
  output logic [WB_ADDR_WIDTH-1:0]   first_bad_adr_o,
  output logic [WB_ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [WB_DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                       wbm_we_o,
  output logic [WB_DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic                       wbm_stb_o,
  output logic                       wbm_cyc_o,
  input  logic                       wbm_ack_i,
  input  logic                       wbm_err_i,
  input  logic                       wbm_stall_i
);

  localparam int unsigned Bytes = WB_DATA_WIDTH / 8;
  localparam logic [WB_ADDR_WIDTH-1:0] AlignMask = {WB_ADDR_WIDTH{1'b1}} << $clog2(Bytes);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

  state_e                   state_q, state_d;
  logic                     check_q, check_d;
  logic [WB_ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]     count_q, count_d;
  logic [WB_DATA_WIDTH-1:0] seed_q, seed_d;
  logic [LEN_WIDTH-1:0]     issued_q, issued_d;
  logic [LEN_WIDTH-1:0]     retired_q, retired_d;
  logic                     stb_q, stb_d;
  logic                     err_q, err_d;
  logic [LEN_WIDTH-1:0]     mism_q, mism_d;
  logic [WB_ADDR_WIDTH-1:0] first_bad_q, first_bad_d;
  logic                     bad_seen_q, bad_seen_d;

  logic                 active, accept, retire;
  logic [LEN_WIDTH-1:0] outst_d;

  function automatic logic [WB_ADDR_WIDTH-1:0] word_adr(input logic [WB_ADDR_WIDTH-1:0] base,
                                                        input logic [LEN_WIDTH-1:0] idx);
    return base + WB_ADDR_WIDTH'(idx) * WB_ADDR_WIDTH'(Bytes);
  endfunction

  always_comb begin
    state_d     = state_q;
    check_d     = check_q;
    base_d      = base_q;
    count_d     = count_q;
    seed_d      = seed_q;
    stb_d       = stb_q;
    err_d       = err_q;
    mism_d      = mism_q;
    first_bad_d = first_bad_q;
    bad_seen_d  = bad_seen_q;

    active = (state_q == StRun) || (state_q == StDrain);
    accept = stb_q && !wbm_stall_i;
    // Responses with nothing outstanding are spurious and dropped.
    retire = active && (wbm_ack_i || wbm_err_i) && (issued_q != retired_q);

    issued_d  = issued_q + LEN_WIDTH'(accept);
    retired_d = retired_q + LEN_WIDTH'(retire);
    outst_d   = issued_d - retired_d;

    if (retire && wbm_err_i) err_d = 1'b1;

    if (retire && !wbm_err_i && check_q &&
        (wbm_dat_i != (seed_q + WB_DATA_WIDTH'(retired_q)))) begin
      if (mism_q != {LEN_WIDTH{1'b1}}) mism_d = mism_q + LEN_WIDTH'(1);
      if (!bad_seen_q) begin
        bad_seen_d  = 1'b1;
        first_bad_d = word_adr(base_q, retired_q);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_start_i) begin
          check_d     = cmd_check_i;
          base_d      = cmd_base_i & AlignMask;
          count_d     = cmd_count_i;
          seed_d      = cmd_seed_i;
          issued_d    = '0;
          retired_d   = '0;
          err_d       = 1'b0;
          mism_d      = '0;
          first_bad_d = '0;
          bad_seen_d  = 1'b0;
          stb_d       = (cmd_count_i != '0);
          state_d     = (cmd_count_i == '0) ? StFinish : StRun;
        end
      end
      StRun: begin
        if ((retire && wbm_err_i) || (issued_d == count_q)) begin
          stb_d   = 1'b0;
          state_d = StDrain;
        end else begin
          stb_d = (outst_d < LEN_WIDTH'(MAX_OUTSTANDING));
        end
      end
      StDrain: begin
        if (outst_d == '0) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      check_q     <= 1'b0;
      base_q      <= '0;
      count_q     <= '0;
      seed_q      <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      mism_q      <= '0;
      first_bad_q <= '0;
      bad_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      check_q     <= check_d;
      base_q      <= base_d;
      count_q     <= count_d;
      seed_q      <= seed_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      mism_q      <= mism_d;
      first_bad_q <= first_bad_d;
      bad_seen_q  <= bad_seen_d;
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StFinish);
  assign err_o           = err_q;
  assign mismatch_cnt_o  = mism_q;
  assign first_bad_adr_o = first_bad_q;
  assign wbm_cyc_o       = active;
  assign wbm_stb_o       = stb_q;
  assign wbm_we_o        = stb_q && !check_q;
  assign wbm_sel_o       = {Bytes{stb_q}};
  assign wbm_adr_o       = stb_q ? word_adr(base_q, issued_q) : '0;
  assign wbm_dat_o       = (stb_q && !check_q) ? (seed_q + WB_DATA_WIDTH'(issued_q)) : '0;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench for wb_mem_tester with a pipelined Wishbone RAM model that supports
// configurable ack latency, random stall, error injection and a corrupted read address.
module tb_wb_mem_tester;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_check;
  logic [31:0] cmd_base, cmd_seed;
  logic [15:0] cmd_count;
  logic        busy, done, err;
  logic [15:0] mism;
  logic [31:0] first_bad;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_we, wbm_stb, wbm_cyc;
  logic [3:0]  wbm_sel;
  logic        wbm_ack = 1'b0, wbm_err = 1'b0, wbm_stall = 1'b0;

  always #5 clk = ~clk;

  wb_mem_tester #(
    .WB_DATA_WIDTH  (32),
    .WB_ADDR_WIDTH  (32),
    .LEN_WIDTH      (16),
    .MAX_OUTSTANDING(2)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .cmd_start_i    (cmd_start),
    .cmd_check_i    (cmd_check),
    .cmd_base_i     (cmd_base),
    .cmd_count_i    (cmd_count),
    .cmd_seed_i     (cmd_seed),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .mismatch_cnt_o (mism),
    .first_bad_adr_o(first_bad),
    .wbm_adr_o      (wbm_adr),
    .wbm_dat_o      (wbm_dat_o),
    .wbm_dat_i      (wbm_dat_i),
    .wbm_we_o       (wbm_we),
    .wbm_sel_o      (wbm_sel),
    .wbm_stb_o      (wbm_stb),
    .wbm_cyc_o      (wbm_cyc),
    .wbm_ack_i      (wbm_ack),
    .wbm_err_i      (wbm_err),
    .wbm_stall_i    (wbm_stall)
  );

  typedef struct {
    int          due;
    logic [31:0] dat;
    bit          err;
  } rsp_t;

  // Slave configuration, written only by the stimulus process.
  int          stall_pct = 0;
  int          lat       = 1;
  int          err_at    = 0;
  logic [31:0] bad_adr   = 32'hFFFF_FFFF;

  // Slave state and monitors, written only by the slave process.
  rsp_t        rq[$];
  logic [31:0] mem    [logic [31:0]];
  int          wr_cnt [logic [31:0]];
  int nedge = 0, req_n = 0, acc_total = 0, wr_total = 0, cyc_hits = 0, done_total = 0;
  int out_n = 0, max_out = 0, viol_hold = 0, viol_err = 0;
  bit          err_seen = 1'b0, stall_prev = 1'b0;
  logic [31:0] adr_prev = '0, dat_prev = '0;

  int n_checks = 0, n_errors = 0;

  function automatic logic [31:0] mval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic int wcnt(input logic [31:0] a);
    return wr_cnt.exists(a) ? wr_cnt[a] : 0;
  endfunction

  // Slave responds at negedge so every input is settled before the next posedge.
  always @(negedge clk) begin
    rsp_t        r;
    bit          acc, ret;
    logic [31:0] rd;
    nedge++;
    ret = 1'b0;
    if (!wbm_cyc) begin
      rq.delete();
      req_n    = 0;
      err_seen = 1'b0;
      out_n    = 0;
    end else begin
      cyc_hits++;
      if (err_seen && wbm_stb) viol_err++;
      if (stall_prev && (!wbm_stb || wbm_adr != adr_prev || wbm_dat_o != dat_prev)) viol_hold++;
    end
    if (done) done_total++;
    wbm_ack   = 1'b0;
    wbm_err   = 1'b0;
    wbm_dat_i = '0;
    if (rq.size() > 0 && rq[0].due <= nedge) begin
      r = rq.pop_front();
      ret = 1'b1;
      wbm_dat_i = r.dat;
      if (r.err) begin
        wbm_err  = 1'b1;
        err_seen = 1'b1;
      end else begin
        wbm_ack = 1'b1;
      end
    end
    wbm_stall = wbm_cyc && ($urandom_range(99) < stall_pct);
    acc = wbm_stb && !wbm_stall;
    if (acc) begin
      req_n++;
      acc_total++;
      rd = (wbm_adr == bad_adr) ? 32'h0 : mval(wbm_adr);
      if (wbm_we) begin
        mem[wbm_adr]    = wbm_dat_o;
        wr_cnt[wbm_adr] = wcnt(wbm_adr) + 1;
        wr_total++;
      end
      r.due = nedge + lat;
      r.dat = rd;
      r.err = (req_n == err_at);
      rq.push_back(r);
    end
    out_n = out_n + int'(acc) - int'(ret);
    if (out_n > max_out) max_out = out_n;
    stall_prev = wbm_stb && wbm_stall;
    adr_prev   = wbm_adr;
    dat_prev   = wbm_dat_o;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  bit          busy1, cyc1, stb1;
  logic [15:0] mism_ab;
  logic [31:0] fb_ab;

  // Issues one command; k_done is the cycle offset of done_o after the start edge (0 if none).
  task automatic run_cmd(input bit chk, input logic [31:0] base, input logic [15:0] cnt,
                         input logic [31:0] seed, input int abort_at, input int restart_at,
                         output int k_done);
    k_done    = 0;
    cmd_check = chk;
    cmd_base  = base;
    cmd_count = cnt;
    cmd_seed  = seed;
    cmd_start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (k == 1) begin
        busy1 = busy;
        cyc1  = wbm_cyc;
        stb1  = wbm_stb;
      end
      if (k == restart_at) cmd_start = 1'b1;
      if (k == abort_at) begin
        mism_ab = mism;
        fb_ab   = first_bad;
        rst     = 1'b1;
        return;
      end
      if (done) begin
        k_done = k;
        check("cyc_low_at_done", wbm_cyc, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    int k, a0, w0, c0, d0;
    rst = 1'b1;
    cmd_start = 1'b0;
    cmd_check = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    cmd_seed  = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, err, wbm_cyc, wbm_stb, wbm_we, wbm_sel}, 10'h0);
    check("reset_status", {mism, first_bad}, 48'h0);
    check("reset_bus", {wbm_adr, wbm_dat_o}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-stall fill, ack latency 1.
    run_cmd(1'b0, 32'h40, 16'd8, 32'h100, 0, 0, k);
    check("fill_first_cycle", {busy1, cyc1, stb1}, 3'b111);
    check("fill_done_cycle", k, 10);
    check("fill_err", err, 1'b0);
    check("fill_mism", mism, 16'd0);
    for (int i = 0; i < 8; i++) begin
      check("fill_data", mval(32'h40 + 32'(4 * i)), 32'h100 + 32'(i));
      check("fill_once", wcnt(32'h40 + 32'(4 * i)), 1);
    end
    @(negedge clk);
    check("fill_busy_after", busy, 1'b0);

    // Clean read-back.
    w0 = wr_total;
    a0 = acc_total;
    run_cmd(1'b1, 32'h40, 16'd8, 32'h100, 0, 0, k);
    check("chk_done_cycle", k, 10);
    check("chk_mism", mism, 16'd0);
    check("chk_first_bad", first_bad, 32'h0);
    check("chk_reads", acc_total - a0, 8);
    check("chk_no_writes", wr_total - w0, 0);
    @(negedge clk);

    // Corrupted word 0x4C: index 3 reads 0 instead of 0x103.
    bad_adr = 32'h4C;
    run_cmd(1'b1, 32'h40, 16'd8, 32'h100, 0, 0, k);
    check("bad_done_cycle", k, 10);
    check("bad_mism", mism, 16'd1);
    check("bad_first_adr", first_bad, 32'h4C);
    repeat (3) @(negedge clk);
    check("bad_status_held", {mism, first_bad}, {16'd1, 32'h4C});

    // Backpressure: 50% stall, ack latency 3, unaligned base gets forced down to 0x200.
    stall_pct = 50;
    lat       = 3;
    run_cmd(1'b0, 32'h203, 16'd8, 32'hA0, 0, 0, k);
    check("stall_done_seen", k != 0, 1'b1);
    stall_pct = 0;
    lat       = 1;
    for (int i = 0; i < 8; i++) begin
      check("stall_data", mval(32'h200 + 32'(4 * i)), 32'hA0 + 32'(i));
      check("stall_once", wcnt(32'h200 + 32'(4 * i)), 1);
    end
    check("stall_hold", viol_hold, 0);
    check("max_outstanding", max_out, 2);
    @(negedge clk);

    // Error on the 3rd request: request 4 is already accepted, drains, then done.
    err_at = 3;
    a0 = acc_total;
    run_cmd(1'b0, 32'h400, 16'd8, 32'h55, 0, 0, k);
    err_at = 0;
    check("err_done_cycle", k, 6);
    check("err_flag", err, 1'b1);
    check("err_accepted", acc_total - a0, 4);
    check("err_no_stb_after", viol_err, 0);
    repeat (4) @(negedge clk);
    check("err_held", err, 1'b1);

    // Zero-length command.
    c0 = cyc_hits;
    run_cmd(1'b0, 32'h800, 16'd0, 32'h1, 0, 0, k);
    check("zero_first_busy", busy1, 1'b1);
    check("zero_done_cycle", k, 1);
    check("zero_err_cleared", err, 1'b0);
    @(negedge clk);
    check("zero_busy_after", busy, 1'b0);
    check("zero_no_cyc", cyc_hits - c0, 0);

    // Start while busy is ignored.
    d0 = done_total;
    run_cmd(1'b0, 32'h500, 16'd8, 32'h9, 0, 3, k);
    check("restart_done_cycle", k, 10);
    repeat (20) @(negedge clk);
    check("restart_one_done", done_total - d0, 1);

    // Reset mid-check: 0x4C is word 1 here, so a mismatch is recorded before the reset.
    d0 = done_total;
    run_cmd(1'b1, 32'h48, 16'd8, 32'h102, 4, 0, k);
    check("pre_reset_mism", {mism_ab, fb_ab}, {16'd1, 32'h4C});
    @(negedge clk);
    rst = 1'b0;
    check("rst_bus_low", {wbm_cyc, wbm_stb, busy, done}, 4'h0);
    check("rst_status", {err, mism, first_bad}, 49'h0);
    repeat (10) @(negedge clk);
    check("rst_no_done", done_total - d0, 0);

    run_cmd(1'b0, 32'h600, 16'd8, 32'h700, 0, 0, k);
    check("post_rst_done_cycle", k, 10);
    check("post_rst_first", mval(32'h600), 32'h700);
    check("post_rst_last", mval(32'h61C), 32'h707);
    check("post_rst_once", wcnt(32'h61C), 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_mem_tester.md
# wb_mem_tester

Pipelined Wishbone B4 initiator that exercises a Wishbone memory slave, such as the on-chip RAM sitting beside the CPU. A command writes an incrementing data pattern into a word range (fill mode) or reads the range back and compares it against the same pattern (check mode). Status is returned through a busy/done/error/mismatch interface. It runs as a second bus master for memory initialisation and self-test in simulation and on the verilator bench.

## Interface
- WB_DATA_WIDTH, 32, data bus width; multiple of 8
- WB_ADDR_WIDTH, 32, byte address width
- LEN_WIDTH, 16, width of word count and mismatch counter
- MAX_OUTSTANDING, 4, maximum issued-but-unretired requests; 1..15
- wb_clk_i  in  1  clock; only clock
- wb_rst_i  in  1  reset; synchronous, active-high
- cmd_start_i  in  1  start pulse; sampled only in IDLE
- cmd_check_i  in  1  0 = fill (write), 1 = check (read+compare); latched at start
- cmd_base_i  in  WB_ADDR_WIDTH  byte base address; low log2(WB_DATA_WIDTH/8) bits forced to 0
- cmd_count_i  in  LEN_WIDTH  number of words
- cmd_seed_i  in  WB_DATA_WIDTH  pattern seed; word i = seed + i, mod 2^WB_DATA_WIDTH
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  a wbm_err_i was seen; held until next accepted start
- mismatch_cnt_o  out  LEN_WIDTH  check-mode mismatches, saturating
- first_bad_adr_o  out  WB_ADDR_WIDTH  address of first mismatch; 0 if none
- wbm_adr_o  out  WB_ADDR_WIDTH  request address
- wbm_dat_o  out  WB_DATA_WIDTH  write data
- wbm_dat_i  in  WB_DATA_WIDTH  read data
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  WB_DATA_WIDTH/8  byte selects; always all ones while stb is high
- wbm_stb_o  out  1  request strobe
- wbm_cyc_o  out  1  bus cycle
- wbm_ack_i  in  1  normal response
- wbm_err_i  in  1  error response
- wbm_stall_i  in  1  slave cannot accept this cycle

## Operation
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE + cmd_start_i:
  - Latch the command fields.
  - Clear err_o, mismatch_cnt_o and first_bad_adr_o.
  - Reset the issued, retired and outstanding counters to 0.
  - If count = 0, go to FINISH with no bus activity. Otherwise assert cyc and stb with request 0 and go to RUN.
- Request i: adr = base + i*(WB_DATA_WIDTH/8), wrapping modulo 2^WB_ADDR_WIDTH; dat = seed + i; we = !check.
- A request is accepted at an edge where stb=1 and stall=0. On acceptance:
  - issued increments.
  - If more words remain and outstanding after this edge < MAX_OUTSTANDING, stb stays high with the next request.
  - Otherwise stb drops.
- While stb=1 and stall=1, adr/dat/we/stb are held stable.
- stb re-asserts when a retirement frees a slot.
- An ack or err at an edge retires one request. outstanding = issued - retired, updated with acceptance and retirement at the same edge.
- ack/err with zero outstanding is ignored.
- Check mode: responses are in order. On each ack, compare wbm_dat_i with seed + retired index.
  - Mismatch: mismatch_cnt_o increments, saturating at 2^LEN_WIDTH-1.
  - First mismatch of the command also loads first_bad_adr_o with that request's address.
- err response: set err_o and stop issuing (stb low); go to DRAIN.
- RUN → DRAIN when issued = count.
- DRAIN: cyc stays high, stb low, until outstanding = 0, then → FINISH.
- FINISH: cyc=0, done_o=1 for this one cycle, then → IDLE. busy_o is high in RUN, DRAIN and FINISH.
- cmd_start_i outside IDLE is ignored.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-command: cyc/stb drop at the reset edge, no done pulse, status cleared.

## Timing
- Start sampled at edge N: busy, cyc and stb are high in cycle N+1.
- Zero-stall slave with ack one cycle after acceptance, MAX_OUTSTANDING ≥ 2:
  - One request accepted per cycle.
  - Final ack at edge N+count+1.
  - done_o is high in cycle N+count+2; cyc is low from that cycle.
  - busy drops at cycle N+count+3.
- count = 0: done_o in cycle N+1, busy low in N+2, cyc never asserted.
- Status outputs are stable from done_o until the next accepted start.

## Test plan
- Fill: base 0x40, count 8, seed 0x100, zero-stall RAM → writes 0x100..0x107 to 0x40..0x5C, one per cycle; done at cycle start+10; err 0; mismatch 0.
- Check, clean: same command with check=1 → 8 reads; mismatch_cnt 0, first_bad_adr 0. Corrupt word 0x4C to 0 → mismatch_cnt 1, first_bad_adr 0x4C.
- Stall/backpressure: random wbm_stall_i 50%, ack latency 3, MAX_OUTSTANDING 2.
  - Outstanding never exceeds 2.
  - adr/dat are held during stall.
  - All 8 words are written exactly once.
- Error: slave returns err on the 3rd request, count 8 → no new stb after that err; cyc drops once outstanding drains; done pulse; err_o=1.
- count = 0 → done pulse in cycle start+1, no cyc; start while busy → ignored, exactly one done.
- Reset after 3 of 8 requests accepted → cyc/stb low the next cycle, no done, all status 0; a new fill then completes normally.
